// File: rtl/core_run_ctrl.sv
// Run controller for a small core: holds it in reset, releases it, detects a halt
// (stable PC) or a cycle-limit timeout, and latches the core's result.
module core_run_ctrl #(
    parameter int unsigned RST_HOLD    = 5,
    parameter int unsigned HALT_REPEAT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [31:0] i_sw_cfg,
    input  logic [31:0] i_max_cycles,
    input  logic [31:0] i_core_pc,
    input  logic [31:0] i_core_out,
    output logic        o_core_rst,
    output logic [31:0] o_core_sw,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout,
    output logic [31:0] o_result,
    output logic [31:0] o_cycle_count
);

    typedef enum logic [2:0] {StIdle, StHold, StRun, StDone, StTout} state_e;

    localparam logic [31:0] HoldLast = 32'(RST_HOLD - 1);
    localparam logic [31:0] HaltLast = 32'(HALT_REPEAT - 1);

    state_e      r_state;
    logic        r_core_rst;
    logic [31:0] r_core_sw;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;
    logic [31:0] r_result;
    logic [31:0] r_cycle_count;
    logic [31:0] r_limit;
    logic [31:0] r_hold_cnt;
    logic [31:0] r_same_cnt;
    logic [31:0] r_prev_pc;
    logic        r_pc_valid;

    logic [31:0] w_cnt_next;
    logic [31:0] w_same_next;
    logic        w_halt;
    logic        w_tout;
    logic        w_launch;

    assign w_cnt_next  = (r_cycle_count == 32'hFFFF_FFFF) ? r_cycle_count : r_cycle_count + 32'd1;
    // prev_pc is meaningless on the first RUN cycle, so the repeat run starts at zero there.
    assign w_same_next = (r_pc_valid && (i_core_pc == r_prev_pc)) ? r_same_cnt + 32'd1 : 32'd0;
    assign w_halt      = (w_same_next == HaltLast);
    assign w_tout      = (r_limit != 32'd0) && (w_cnt_next == r_limit);
    // abort only blocks a launch from IDLE; in DONE/TOUT it is ignored entirely.
    assign w_launch    = i_start && !(r_state == StIdle && i_abort);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_core_rst    <= 1'b1;
            r_core_sw     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_result      <= '0;
            r_cycle_count <= '0;
            r_limit       <= '0;
            r_hold_cnt    <= '0;
            r_same_cnt    <= '0;
            r_prev_pc     <= '0;
            r_pc_valid    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone, StTout: begin
                    if (w_launch) begin
                        r_state       <= StHold;
                        r_core_sw     <= i_sw_cfg;
                        r_limit       <= i_max_cycles;
                        r_hold_cnt    <= '0;
                        r_done        <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_cycle_count <= '0;
                        r_same_cnt    <= '0;
                        r_pc_valid    <= 1'b0;
                        r_busy        <= 1'b1;
                        r_core_rst    <= 1'b1;
                    end
                end
                StHold: begin
                    if (i_abort) begin
                        r_state    <= StIdle;
                        r_busy     <= 1'b0;
                        r_core_rst <= 1'b1;
                    end else if (r_hold_cnt == HoldLast) begin
                        r_state    <= StRun;
                        r_core_rst <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end
                StRun: begin
                    if (i_abort) begin
                        r_state    <= StIdle;
                        r_busy     <= 1'b0;
                        r_core_rst <= 1'b1;
                    end else begin
                        r_cycle_count <= w_cnt_next;
                        r_prev_pc     <= i_core_pc;
                        r_pc_valid    <= 1'b1;
                        r_same_cnt    <= w_same_next;
                        if (w_halt) begin
                            r_state    <= StDone;
                            r_result   <= i_core_out;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_core_rst <= 1'b1;
                        end else if (w_tout) begin
                            r_state    <= StTout;
                            r_result   <= i_core_out;
                            r_timeout  <= 1'b1;
                            r_busy     <= 1'b0;
                            r_core_rst <= 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_core_rst    = r_core_rst;
    assign o_core_sw     = r_core_sw;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;
    assign o_result      = r_result;
    assign o_cycle_count = r_cycle_count;

endmodule
